// File: rtl/booth_job_sequencer_pkg.sv
// Shared definitions for the Booth job sequencer: default operand width and
// the 3-bit sequencer state encoding.
package booth_pkg;

  localparam int BOOTH_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_LOAD_M  = 3'd2,
    ST_LOAD_Q  = 3'd3,
    ST_WAIT    = 3'd4,
    ST_RESULT  = 3'd5,
    ST_RESTART = 3'd6
  } seq_state_e;

endpackage

// File: rtl/booth_job_sequencer_if.sv
// Bundles the operand, core and result handshakes of the Booth job sequencer.
// master = sequencer side, slave = producer/core/consumer side.
interface booth_job_sequencer_if #(
  parameter int WIDTH = booth_pkg::BOOTH_WIDTH
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_m;
  logic [WIDTH-1:0]   in_q;
  logic               core_start;
  logic [WIDTH-1:0]   core_data;
  logic               core_done;
  logic [2*WIDTH-1:0] core_prod;
  logic               core_restart;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic               out_err;

  modport master (
    input  in_valid, in_m, in_q, core_done, core_prod, out_ready,
    output in_ready, core_start, core_data, core_restart, out_valid, out_prod, out_err
  );

  modport slave (
    output in_valid, in_m, in_q, core_done, core_prod, out_ready,
    input  in_ready, core_start, core_data, core_restart, out_valid, out_prod, out_err
  );
endinterface

// File: rtl/booth_job_sequencer_operand_reg.sv
// M/Q capture register pair; holds the accepted operand pair for one job.
module booth_operand_reg #(
  parameter int WIDTH = booth_pkg::BOOTH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] m_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] m_q, q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      q_q <= '0;
    end else if (load_i) begin
      m_q <= m_i;
      q_q <= q_i;
    end
  end

  assign m_o = m_q;
  assign q_o = q_q;

endmodule

// File: rtl/booth_job_sequencer.sv
// Feeds one operand pair at a time into the Booth core (start, M, Q), waits
// for done, and offers the product on a valid/ready port. Optional WAIT
// timeout is enabled with BOOTH_SEQ_TIMEOUT_EN.
module booth_job_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
`ifdef BOOTH_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_job_sequencer_if.master bus
);

  seq_state_e         state_q, state_d;
  logic [WIDTH-1:0]   op_m, op_q;
  logic [WIDTH-1:0]   core_data_mux;
  logic               accept;
  logic               capture_done;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] out_prod_q;
  logic               timeout;

  assign accept       = (state_q == ST_IDLE) && bus.in_valid;
  assign capture_done = (state_q == ST_WAIT) && bus.core_done;

  booth_operand_reg #(.WIDTH(WIDTH)) u_opreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .m_i    (bus.in_m),
    .q_i    (bus.in_q),
    .m_o    (op_m),
    .q_o    (op_q)
  );

`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             out_err_q;

  // Cleared while loading Q so the first WAIT cycle counts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tmo_cnt_q <= '0;
    else if (state_q == ST_LOAD_Q) tmo_cnt_q <= '0;
    else if (state_q == ST_WAIT)   tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end

  assign timeout = (state_q == ST_WAIT) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            out_err_q <= 1'b0;
    else if (capture_done) out_err_q <= 1'b0;
    else if (timeout)      out_err_q <= 1'b1;
  end

  assign bus.out_err = out_err_q;
`else
  assign timeout     = 1'b0;
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.in_valid) state_d = ST_START;
      ST_START:   state_d = ST_LOAD_M;
      ST_LOAD_M:  state_d = ST_LOAD_Q;
      ST_LOAD_Q:  state_d = ST_WAIT;
      ST_WAIT:    if (bus.core_done || timeout) state_d = ST_RESULT;
      ST_RESULT:  if (bus.out_ready) state_d = ST_RESTART;
      ST_RESTART: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Done takes priority over a coincident timeout; an abort reports a zero product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
    end else if (capture_done) begin
      out_valid_q <= 1'b1;
      out_prod_q  <= bus.core_prod;
    end else if (timeout) begin
      out_valid_q <= 1'b1;
      out_prod_q  <= '0;
    end else if ((state_q == ST_RESULT) && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_comb begin
    core_data_mux = '0;
    case (state_q)
      ST_LOAD_M: core_data_mux = op_m;
      ST_LOAD_Q: core_data_mux = op_q;
      default:   core_data_mux = '0;
    endcase
  end

  assign bus.in_ready     = (state_q == ST_IDLE);
  assign bus.core_start   = (state_q == ST_START);
  assign bus.core_restart = (state_q == ST_RESTART);
  assign bus.core_data    = core_data_mux;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_prod     = out_prod_q;

endmodule

// File: tb/tb_booth_job_sequencer.sv
// Directed bench for booth_job_sequencer with a behavioural Booth core model
// (samples M then Q after start, raises done a fixed number of cycles later).
module tb_booth_job_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_job_sequencer_if #(.WIDTH(16)) bus ();

  booth_job_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- core model ----------------
  logic        mdl_done;
  logic [31:0] mdl_prod;
  logic [15:0] mdl_m;
  int          mdl_st, mdl_cnt;
  int          done_delay = 17;
  bit          never_done = 1'b0;
  logic        glitch = 1'b0;

  assign bus.core_done = mdl_done | glitch;
  assign bus.core_prod = mdl_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_st <= 0; mdl_cnt <= 0; mdl_done <= 1'b0; mdl_prod <= '0; mdl_m <= '0;
    end else if (bus.core_restart) begin
      mdl_st <= 0; mdl_done <= 1'b0;
    end else begin
      case (mdl_st)
        0: if (bus.core_start) mdl_st <= 1;
        1: begin mdl_m <= bus.core_data; mdl_st <= 2; end
        2: begin
          mdl_prod <= $signed({{16{mdl_m[15]}}, mdl_m}) *
                      $signed({{16{bus.core_data[15]}}, bus.core_data});
          mdl_cnt  <= 0;
          mdl_st   <= 3;
        end
        default: if (!never_done && !mdl_done) begin
          mdl_cnt <= mdl_cnt + 1;
          if (mdl_cnt + 1 == done_delay) mdl_done <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "/in_ready"},     64'(bus.in_ready),     64'd1);
    chk({nm, "/core_start"},   64'(bus.core_start),   64'd0);
    chk({nm, "/core_data"},    64'(bus.core_data),    64'd0);
    chk({nm, "/core_restart"}, 64'(bus.core_restart), 64'd0);
    chk({nm, "/out_valid"},    64'(bus.out_valid),    64'd0);
    chk({nm, "/out_prod"},     64'(bus.out_prod),     64'd0);
    chk({nm, "/out_err"},      64'(bus.out_err),      64'd0);
  endtask

  // One full job: accept, check bus sequence, latency, result, hold, restart.
  task automatic run_job(input logic [15:0] m, input logic [15:0] q, input logic [31:0] exp_p,
                         input logic exp_err, input int exp_lat, input int hold,
                         input bit glt, input string nm);
    int cyc;
    @(negedge clk);
    bus.in_m = m; bus.in_q = q; bus.in_valid = 1'b1;
    cyc = 0;
    while (!bus.in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_m = 16'hDEAD; bus.in_q = 16'hBEEF;
    chk({nm, "/start"}, 64'({bus.core_start, bus.in_ready}), 64'b10);
    @(negedge clk);
    chk({nm, "/load_m"}, 64'({bus.core_start, bus.core_data}), 64'({1'b0, m}));
    glitch = glt;
    @(negedge clk);
    glitch = 1'b0;
    chk({nm, "/load_q"}, 64'(bus.core_data), 64'(q));
    cyc = 2;
    @(negedge clk); cyc++;
    chk({nm, "/wait_bus"}, 64'({bus.core_data, bus.out_valid}), 64'd0);
    while (!bus.out_valid && cyc < 400) begin @(negedge clk); cyc++; end
    chk({nm, "/latency"}, 64'(cyc), 64'(exp_lat));
    chk({nm, "/prod"},    64'(bus.out_prod), 64'(exp_p));
    chk({nm, "/err"},     64'(bus.out_err),  64'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "/hold"}, 64'({bus.out_valid, bus.in_ready, bus.out_prod}), 64'({2'b10, exp_p}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, "/restart"}, 64'({bus.out_valid, bus.core_restart}), 64'b01);
    @(negedge clk);
    chk({nm, "/idle"}, 64'({bus.core_restart, bus.in_ready}), 64'b01);
  endtask

  typedef struct {
    logic [15:0] m;
    logic [15:0] q;
    logic [31:0] p;
    int          dly;
    int          hold;
    bit          glt;
    string       nm;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int starts, rsts, got, sent;
    logic [31:0] prods[2];

    vecs[0] = '{16'h0003, 16'hFFFE, 32'hFFFFFFFA, 17, 0,  1'b0, "3x-2"};
    vecs[1] = '{16'h8000, 16'h8000, 32'h40000000, 17, 10, 1'b0, "min_x_min"};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, 17, 0,  1'b0, "max_x_max"};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 32'h00000001, 17, 1,  1'b0, "neg1_sq"};
    vecs[4] = '{16'h0000, 16'h1234, 32'h00000000, 17, 0,  1'b0, "zero"};
    vecs[5] = '{16'h1234, 16'h0002, 32'h00002468, 1,  0,  1'b0, "fast_done"};
    vecs[6] = '{16'h0005, 16'hFFFB, 32'hFFFFFFE7, 17, 0,  1'b1, "done_glitch"};

    bus.in_valid = 1'b0; bus.in_m = '0; bus.in_q = '0; bus.out_ready = 1'b0;
    #3;
    chk_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_reset");

    for (int i = 0; i < 7; i++) begin
      done_delay = vecs[i].dly;
      run_job(vecs[i].m, vecs[i].q, vecs[i].p, 1'b0, 4 + vecs[i].dly,
              vecs[i].hold, vecs[i].glt, vecs[i].nm);
    end

    // Back-to-back with in_valid held high across both jobs.
    done_delay = 17;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_m = 16'd7; bus.in_q = 16'd6; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_m = 16'hFFFB; bus.in_q = 16'd5;
    starts = 0; rsts = 0; got = 0; sent = 1;
    for (int c = 0; c < 200 && got < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.core_start) begin
        starts++;
        if (starts == 2) chk("b2b/restart_before_2nd_start", 64'(rsts), 64'd1);
      end
      if (bus.core_restart) rsts++;
      if (bus.out_valid) begin prods[got] = bus.out_prod; got++; end
      if (sent == 2 && !bus.in_ready) bus.in_valid = 1'b0;
      if (sent == 1 && bus.in_ready) sent = 2;
    end
    chk("b2b/got",    64'(got), 64'd2);
    chk("b2b/prod0",  64'(prods[0]), 64'd42);
    chk("b2b/prod1",  64'(prods[1]), 64'hFFFFFFE7);
    chk("b2b/starts", 64'(starts), 64'd2);
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    chk("b2b/final_restart", 64'({bus.core_restart, bus.out_valid}), 64'b10);
    @(negedge clk);

    // Asynchronous reset while the core is computing.
    @(negedge clk);
    bus.in_m = 16'h0011; bus.in_q = 16'h0022; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk); rst_n = 1'b1;
    rsts = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.core_restart) rsts++;
    end
    chk("async_rst/no_restart", 64'({rsts[7:0], bus.in_ready}), 64'({8'd0, 1'b1}));
    run_job(16'hFFFD, 16'h0004, 32'hFFFFFFF4, 1'b0, 21, 0, 1'b0, "after_rst");

`ifdef BOOTH_SEQ_TIMEOUT_EN
    never_done = 1'b1;
    run_job(16'h1234, 16'h5678, 32'h0, 1'b1, 67, 2, 1'b0, "timeout");
    never_done = 1'b0;
    done_delay = 63;
    run_job(16'h0003, 16'hFFFE, 32'hFFFFFFFA, 1'b0, 67, 0, 1'b0, "done_vs_tmo");
`else
    done_delay = 100;
    run_job(16'h0002, 16'h0003, 32'h00000006, 1'b0, 104, 0, 1'b0, "long_wait");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
